// File: rtl/dctq_quant_ctrl_if.sv
// Coefficient-in / quantised-result-out stream bundle for dctq_quant_ctrl.
// The slave side is the controller; the master side is the surrounding datapath.
interface dctq_quant_ctrl_if #(
    parameter int unsigned COEF_W = 12,
    parameter int unsigned OUT_W  = 9,
    parameter int unsigned IDX_W  = 6
) ();
    logic              coef_valid;
    logic              coef_ready;
    logic [COEF_W-1:0] coef_data;
    logic              out_valid;
    logic [IDX_W-1:0]  out_idx;
    logic [OUT_W-1:0]  out_data;

    modport master (
        output coef_valid,
        output coef_data,
        input  coef_ready,
        input  out_valid,
        input  out_idx,
        input  out_data
    );

    modport slave (
        input  coef_valid,
        input  coef_data,
        output coef_ready,
        output out_valid,
        output out_idx,
        output out_data
    );
endinterface

// File: rtl/dctq_quant_ctrl.sv
// Sequences one 8x8 DCT block through the pipelined quantisation multiplier,
// pairing each coefficient with its reciprocal and tagging results with their index.
module dctq_quant_ctrl #(
    parameter int unsigned MULT_LAT = 8,
    parameter int unsigned COEF_W   = 12,
    parameter int unsigned Q_W      = 8,
    parameter int unsigned OUT_W    = 9,
    parameter int unsigned BLK_N    = 64,
    parameter int unsigned IDX_W    = $clog2(BLK_N)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                qt_we,
    input  logic [IDX_W-1:0]    qt_addr,
    input  logic [Q_W-1:0]      qt_data,
    input  logic                blk_start,
    dctq_quant_ctrl_if.slave    cif,
    output logic [COEF_W-1:0]   mult_n1,
    output logic [Q_W-1:0]      mult_n2,
    input  logic [OUT_W-1:0]    mult_dctq,
    output logic                busy,
    output logic                blk_done
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [Q_W-1:0]   qt_q [BLK_N];
    logic [MULT_LAT:0] tag_vld_q;
    logic [IDX_W-1:0] tag_idx_q [MULT_LAT+1];
    logic             accept;
    logic             out_valid;

    assign accept = (state_q == StRun) && cif.coef_valid;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        busy     = 1'b0;
        blk_done = 1'b0;
        cif.coef_ready = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (blk_start) begin
                    state_d = StRun;
                    idx_d   = '0;
                end
            end
            StRun: begin
                busy           = 1'b1;
                cif.coef_ready = 1'b1;
                if (accept) begin
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(BLK_N - 1)) state_d = StDrain;
                end
            end
            StDrain: begin
                busy = 1'b1;
                // The oldest stage leaves this cycle, so only younger stages matter.
                if (tag_vld_q[MULT_LAT-1:0] == '0) state_d = StDone;
            end
            StDone: begin
                blk_done = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            mult_n1 <= '0;
            mult_n2 <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mult_n1 <= accept ? cif.coef_data : '0;
            mult_n2 <= accept ? qt_q[idx_q] : '0;
        end
    end

    // Tag pipeline mirrors the multiplier latency; bubbles carry valid=0, idx=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_q <= '0;
            for (int i = 0; i <= int'(MULT_LAT); i++) tag_idx_q[i] <= '0;
        end else begin
            tag_vld_q    <= {tag_vld_q[MULT_LAT-1:0], accept};
            tag_idx_q[0] <= accept ? idx_q : '0;
            for (int i = 1; i <= int'(MULT_LAT); i++) tag_idx_q[i] <= tag_idx_q[i-1];
        end
    end

    // Table is frozen while a block is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(BLK_N); i++) qt_q[i] <= '0;
        end else if (qt_we && !busy) begin
            qt_q[qt_addr] <= qt_data;
        end
    end

    assign out_valid    = tag_vld_q[MULT_LAT];
    assign cif.out_valid = out_valid;
    assign cif.out_idx   = tag_idx_q[MULT_LAT];
    assign cif.out_data  = out_valid ? mult_dctq : '0;

endmodule
